// File: rtl/barrett_pkg.sv
// Shared widths and sequencer state encoding for the Barrett modexp controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package barrett_pkg;

   localparam int DATA_W = 64;
   localparam int MU_W   = 31;
   localparam int K_W    = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQR  = 2'd1,
      MUL  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/modexp_msb_find.sv
// Priority encoder: index of the highest set bit of vec, plus an all-zero flag.
// Latency: combinational.
// Backpressure: none.
module modexp_msb_find #(
   parameter int EXP_W = 16,
   parameter int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1
) (
   input  logic [EXP_W-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             zero
);

   // Scan upwards so the last hit is the most significant set bit.
   always_comb begin
      idx  = '0;
      zero = (vec == '0);
      for (int i = 0; i < EXP_W; i++) begin
         if (vec[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/barrett_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for base^exp mod q over an external Barrett multiplier.
// Latency: (EXP_W + popcount(exp)) * MUL_LAT cycles from start to done; one cycle when q < 2.
// Backpressure: none; start is ignored while busy. MODEXP_LZ_SKIP_EN skips leading exponent zeros.
module barrett_modexp_ctrl
   import barrett_pkg::*;
#(
   parameter int EXP_W   = 16,
   parameter int MUL_LAT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] base,
   input  logic [EXP_W-1:0]  exp,
   input  logic [DATA_W-1:0] q,
   input  logic [MU_W-1:0]   mu,
   input  logic [K_W-1:0]    k,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] result,
   output logic [DATA_W-1:0] mm_a,
   output logic [DATA_W-1:0] mm_b,
   output logic [DATA_W-1:0] mm_q,
   output logic [MU_W-1:0]   mm_mu,
   output logic [K_W-1:0]    mm_k,
   input  logic [DATA_W-1:0] mm_t
);

   localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] base_r, res_r;
   logic [EXP_W-1:0]  exp_r;
   logic [IDX_W-1:0]  idx, idx_init;
   logic [CNT_W-1:0]  cnt;
   logic              op_done, q_bad, exp_zero;

   // The multiplier has no handshake: an operation is complete after MUL_LAT held cycles.
   assign op_done = (cnt == CNT_W'(MUL_LAT - 1));
   assign q_bad   = (q < DATA_W'(2));

`ifdef MODEXP_LZ_SKIP_EN
   modexp_msb_find #(
      .EXP_W (EXP_W),
      .IDX_W (IDX_W)
   ) u_msb_find (
      .vec  (exp),
      .idx  (idx_init),
      .zero (exp_zero)
   );
`else
   assign idx_init = IDX_W'(EXP_W - 1);
   assign exp_zero = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode and operand/status outputs; operands are held stable by res_r/base_r.
   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      done      = (state == DONE);
      mm_a      = '0;
      mm_b      = '0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (q_bad || exp_zero) ? DONE : SQR;
         end
         SQR: begin
            mm_a = res_r;
            mm_b = res_r;
            if (op_done) begin
               if (exp_r[idx])     state_nxt = MUL;
               else if (idx == '0) state_nxt = DONE;
            end
         end
         MUL: begin
            mm_a = res_r;
            mm_b = base_r;
            if (op_done) state_nxt = (idx == '0) ? DONE : SQR;
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand latch at start, per-operation hold counter, result capture and bit walk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_r <= '0;
         res_r  <= '0;
         exp_r  <= '0;
         idx    <= '0;
         cnt    <= '0;
         err    <= 1'b0;
         result <= '0;
         mm_q   <= '0;
         mm_mu  <= '0;
         mm_k   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  base_r <= base;
                  exp_r  <= exp;
                  mm_q   <= q;
                  mm_mu  <= mu;
                  mm_k   <= k;
                  res_r  <= DATA_W'(1);
                  idx    <= idx_init;
                  cnt    <= '0;
                  err    <= q_bad;
                  if (q_bad)         result <= '0;
                  else if (exp_zero) result <= DATA_W'(1);
               end
            end
            SQR, MUL: begin
               if (op_done) begin
                  res_r <= mm_t;
                  cnt   <= '0;
                  if (state_nxt == DONE) result <= mm_t;
                  // Moving on to the next exponent bit (a square after a multiply, or a skipped multiply).
                  if (state_nxt == SQR) idx <= idx - 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_barrett_modexp_ctrl.sv
// Self-checking bench for barrett_modexp_ctrl with a delayed behavioural a*b mod q multiplier.
// Latency: n/a.
// Backpressure: n/a. Honors MODEXP_LZ_SKIP_EN when computing expected latency.
module tb_barrett_modexp_ctrl;

   localparam int EXP_W   = 16;
   localparam int MUL_LAT = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [63:0]      base = '0;
   logic [EXP_W-1:0] ex = '0;
   logic [63:0]      q = '0;
   logic [30:0]      mu = '0;
   logic [7:0]       k = '0;
   logic             busy, done, err;
   logic [63:0]      result, mm_a, mm_b, mm_q, mm_t;
   logic [30:0]      mm_mu;
   logic [7:0]       mm_k;

   int n_checks = 0;
   int n_errors = 0;

   barrett_modexp_ctrl #(.EXP_W(EXP_W), .MUL_LAT(MUL_LAT)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .base   (base),
      .exp    (ex),
      .q      (q),
      .mu     (mu),
      .k      (k),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .result (result),
      .mm_a   (mm_a),
      .mm_b   (mm_b),
      .mm_q   (mm_q),
      .mm_mu  (mm_mu),
      .mm_k   (mm_k),
      .mm_t   (mm_t)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m);
      logic [127:0] p;
      if (m == 64'd0) return 64'd0;
      p = {64'd0, a} * {64'd0, b};
      return 64'(p % {64'd0, m});
   endfunction

   // Multiplier stand-in: result appears MUL_LAT-1 edges after the operands, so it is
   // only correct when sampled on the MUL_LAT-th edge of a held operation.
   logic [63:0] pipe [MUL_LAT-1];
   initial for (int i = 0; i < MUL_LAT - 1; i++) pipe[i] = 64'd0;
   always @(posedge clk) begin
      pipe[0] <= mulmod(mm_a, mm_b, mm_q);
      for (int i = 1; i < MUL_LAT - 1; i++) pipe[i] <= pipe[i-1];
   end
   assign mm_t = pipe[MUL_LAT-2];

   // Reference: base multiplied into 1 exp times, modulo q.
   function automatic logic [63:0] ref_pow(input logic [63:0] b, input logic [EXP_W-1:0] e, input logic [63:0] m);
      logic [63:0] r;
      if (m < 64'd2) return 64'd0;
      r = 64'd1;
      for (int i = 0; i < int'(e); i++) r = mulmod(r, b, m);
      return r;
   endfunction

   function automatic int ref_lat(input logic [EXP_W-1:0] e, input logic [63:0] m);
      int ops;
      int msb;
      if (m < 64'd2) return 0;
`ifdef MODEXP_LZ_SKIP_EN
      if (e == '0) return 0;
      msb = 0;
      for (int i = 0; i < EXP_W; i++) if (e[i]) msb = i;
      ops = msb + 1 + $countones(e);
`else
      msb = EXP_W - 1;
      ops = msb + 1 + $countones(e);
`endif
      return ops * MUL_LAT;
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // One full operation: start at E0, optional stray start pulse at cycle 'glitch',
   // inputs scrambled right after E0, then result/latency/pulse-width checks.
   task automatic run_op(input logic [63:0] b, input logic [EXP_W-1:0] e, input logic [63:0] m,
                         input logic [30:0] mu_i, input logic [7:0] k_i, input int glitch);
      logic [63:0] want;
      int lat;
      int cyc;
      want = ref_pow(b, e, m);
      lat  = ref_lat(e, m);
      @(negedge clk);
      base = b; ex = e; q = m; mu = mu_i; k = k_i; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      base = {$urandom(), $urandom()};
      ex   = EXP_W'($urandom());
      q    = {$urandom(), $urandom()};
      mu   = 31'($urandom());
      k    = 8'($urandom());
      cyc  = 0;
      while (!done && cyc < 4000) begin
         @(posedge clk); #1;
         cyc++;
         start = (cyc == glitch);
      end
      start = 1'b0;
      check_val("done_seen", 64'(done), 64'd1);
      check_val("latency", 64'(cyc), 64'(lat));
      check_val("result", result, want);
      check_val("err", 64'(err), 64'(m < 64'd2));
      check_val("busy_at_done", 64'(busy), 64'd1);
      check_val("mm_q_held", mm_q, m);
      check_val("mm_mu_held", 64'(mm_mu), 64'(mu_i));
      check_val("mm_k_held", 64'(mm_k), 64'(k_i));
      @(posedge clk); #1;
      check_val("done_pulse_end", 64'(done), 64'd0);
      check_val("busy_end", 64'(busy), 64'd0);
      check_val("result_held", result, want);
   endtask

   initial begin
      logic [63:0] rq, rb;
      logic        seen_done;

      #1;
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_done", 64'(done), 64'd0);
      check_val("rst_err", 64'(err), 64'd0);
      check_val("rst_result", result, 64'd0);
      check_val("rst_mm_a", mm_a, 64'd0);
      check_val("rst_mm_b", mm_b, 64'd0);
      check_val("rst_mm_q", mm_q, 64'd0);
      check_val("rst_mm_mu", 64'(mm_mu), 64'd0);
      check_val("rst_mm_k", 64'(mm_k), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors.
      run_op(64'd3, 16'd5, 64'd7, 31'd0, 8'd0, -1);
      run_op(64'd3, 16'd5, 64'd7, 31'd5, 8'd3, 10);
      run_op(64'd2, 16'd10, 64'd1000, 31'd0, 8'd0, -1);
      run_op(64'd2, 16'd0, 64'd1000, 31'd0, 8'd0, -1);
      run_op(64'd146712, 16'd2, 64'd768112, 31'd1431447, 8'd20, -1);
      run_op(64'd5, 16'd123, 64'd1, 31'd0, 8'd0, 3);
      run_op(64'd9, 16'd7, 64'd0, 31'd0, 8'd0, -1);
      run_op(64'd11, 16'hFFFF, 64'd1000003, 31'd7, 8'd9, -1);
      run_op(64'd6, 16'h8000, 64'd97, 31'd1, 8'd1, -1);

      // Random vectors with base < q.
      for (int t = 0; t < 10; t++) begin
         rq = {$urandom(), $urandom()};
         if (rq < 64'd2) rq = rq + 64'd2;
         rb = {$urandom(), $urandom()} % rq;
         run_op(rb, EXP_W'($urandom_range(0, 65535)), rq, 31'($urandom()), 8'($urandom()),
                (t % 3 == 0) ? $urandom_range(1, 40) : -1);
      end

      // Reset mid-run: outputs clear immediately and no done follows.
      @(negedge clk);
      base = 64'd3; ex = 16'd5; q = 64'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_val("midrst_busy", 64'(busy), 64'd0);
      check_val("midrst_done", 64'(done), 64'd0);
      check_val("midrst_result", result, 64'd0);
      check_val("midrst_mm_q", mm_q, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int c = 0; c < 80; c++) begin
         @(posedge clk); #1;
         seen_done = seen_done | done | busy;
      end
      check_val("midrst_no_done", 64'(seen_done), 64'd0);
      run_op(64'd3, 16'd5, 64'd7, 31'd0, 8'd0, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/barrett_modexp_ctrl.md
Name: barrett_modexp_ctrl

Overview:
Sequencer computing result = base^exp mod q by left-to-right square-and-multiply. It drives one shared vedic_barrett modular multiplier through mm_* ports. vedic_barrett has no handshake, so each issued operation is held for a fixed MUL_LAT cycles before mm_t is captured. The block sits between a host/register interface and the vedic_barrett instance.

Parameters:
- EXP_W, 16: exponent width in bits.
- MUL_LAT, 3: cycles operands are held before mm_t is sampled; must be at least 1.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base  in  64  operand; must be less than q.
- exp  in  EXP_W  exponent.
- q  in  64  modulus.
- mu  in  31  Barrett constant, floor(2^(2k)/q).
- k  in  8  Barrett shift.
- busy  out  1  high from the cycle after start through the DONE cycle.
- done  out  1  one-cycle pulse when result is valid.
- err  out  1  valid with done; set when q < 2.
- result  out  64  final value; held until the next start.
- mm_a, mm_b  out  64  multiplier operands.
- mm_q  out  64  latched q, passed through.
- mm_mu  out  31  latched mu, passed through.
- mm_k  out  8  latched k, passed through.
- mm_t  in  64  multiplier result.

Behaviour:
- Reset, asynchronous, and state on release:
  - state IDLE.
  - busy, done, err = 0.
  - result, mm_a, mm_b, mm_q, mm_mu, mm_k = 0.
  - internal counters = 0.
- States: IDLE, SQR, MUL, DONE.
- IDLE with start=1 at edge E0:
  - Latch base, exp, q, mu and k.
  - Set res_r = 1, idx = EXP_W-1, cnt = 0.
  - If q < 2, go to DONE with err=1 and result=0.
  - Otherwise go to SQR.
- SQR:
  - Drive mm_a = mm_b = res_r; cnt increments each cycle.
  - On the edge where cnt == MUL_LAT-1, capture res_r = mm_t and clear cnt.
  - If exp_r[idx] = 1, go to MUL.
  - Otherwise, if idx == 0 go to DONE; else decrement idx and stay in SQR.
- MUL:
  - Drive mm_a = res_r, mm_b = base_r, with the same MUL_LAT-cycle capture.
  - Then, if idx == 0 go to DONE; else decrement idx and go to SQR.
- DONE:
  - done = 1 and result = res_r for exactly one cycle, then return to IDLE.
  - busy drops together with done.
- Operand hold: mm_a and mm_b are stable for all MUL_LAT cycles of an operation. mm_q, mm_mu and mm_k are constant from E0 until the next start.
- Latency:
  - N_ops = EXP_W + popcount(exp).
  - done is high in the cycle after edge E0 + N_ops*MUL_LAT.
  - For the q < 2 error path, done is high in the cycle after E0.
- Boundary cases:
  - exp = 0: all squarings of 1, result = 1.
  - start while busy, or during DONE: ignored.
  - Input changes after E0: no effect.
  - rst_n asserted mid-operation: immediate return to IDLE, no done pulse, result cleared.
- Arithmetic: all values are 64-bit and mm_t is trusted to be less than q. There is no internal reduction.

Optional Feature:
MODEXP_LZ_SKIP_EN
- Defined: at start, idx is loaded with the index of the highest set bit of exp, and res_r is initialised as before. N_ops = (msb+1) + popcount(exp). exp = 0 goes straight to DONE with result = 1, one cycle after E0.
- Undefined: idx always starts at EXP_W-1, giving fixed-schedule latency that is independent of exp except through popcount.

Decomposition:
- Package barrett_pkg:
  - DATA_W = 64, MU_W = 31, K_W = 8.
  - State enum {IDLE, SQR, MUL, DONE}.
- Sub-module modexp_msb_find: combinational priority encoder, EXP_W in, index out plus a zero flag. It is instantiated only under MODEXP_LZ_SKIP_EN.
- vedic_barrett stays external. The bench instantiates it, or a behavioural a*b mod q model with MUL_LAT delay, on the mm_* ports.

Test Plan:
1. Behavioural model; base=3, exp=5, q=7, EXP_W=16, MUL_LAT=3 -> result=5, err=0. 18 ops, so done in the cycle after E0+54.
2. Behavioural model; base=2, exp=10, q=1000 -> result=24. exp=0 -> result=1, done after E0+48.
3. Real vedic_barrett with q=768112, mu=1431447, k=20; base=146712, exp=2 -> result=376480.
4. q=1, any base and exp -> err=1, result=0, done in the cycle after E0. A second start pulsed mid-run in test 1 is ignored and still yields 5.
5. rst_n low for 1 cycle mid-run -> busy=0, result=0, no done pulse. A fresh start afterwards completes correctly.
6. With MODEXP_LZ_SKIP_EN defined; base=3, exp=5, q=7 -> result=5 after 5 ops (done after E0+15). exp=0 -> result=1 in the cycle after E0.
